// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V privilege, CSR address and PMP config types
package riscv;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_addr_mode_t;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } pmpcfg_access_t;

  // Field order matches the architectural pmpcfg byte: L | 00 | A | X W R
  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    pmpcfg_access_t access;
  } pmpcfg_t;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

endpackage

// File: rtl/pmp_csr_regs_entry.sv
// rtl/pmp_csr_regs_entry.sv - one PMP entry: cfg byte and address register with lock/WARL rules
module pmp_entry_reg
  import riscv::*;
#(
  parameter int unsigned PMP_LEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_we_i,
  input  pmpcfg_t            cfg_wdata_i,
  input  logic               addr_we_i,
  input  logic [PMP_LEN-1:0] addr_wdata_i,
  input  logic               next_locked_tor_i,
  output pmpcfg_t            conf_o,
  output logic [PMP_LEN-1:0] conf_addr_o,
  output logic               changed_o
);

  pmpcfg_t            cfg_d, cfg_q;
  logic [PMP_LEN-1:0] addr_d, addr_q;
  logic               cfg_ok, addr_ok;

  always_comb begin
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    // R=0/W=1 is reserved; such a write leaves the old value in place
    cfg_ok  = cfg_we_i && !cfg_q.locked &&
              !(!cfg_wdata_i.access.r && cfg_wdata_i.access.w);
    // A locked TOR entry above also freezes this entry's address (its lower bound)
    addr_ok = addr_we_i && !cfg_q.locked && !next_locked_tor_i;
    if (cfg_ok) begin
      cfg_d          = cfg_wdata_i;
      cfg_d.reserved = 2'b00;
    end
    if (addr_ok) begin
      addr_d = addr_wdata_i;
    end
    changed_o = (cfg_d != cfg_q) || (addr_d != addr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q  <= '0;
      addr_q <= '0;
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
    end
  end

  assign conf_o      = cfg_q;
  assign conf_addr_o = addr_q;

endmodule

// File: rtl/pmp_csr_regs.sv
// rtl/pmp_csr_regs.sv - machine-mode PMP CSR bank feeding the pmp checker
module pmp_csr_regs
  import riscv::*;
#(
  parameter int unsigned NR_ENTRIES = 4,
  parameter int unsigned PMP_LEN    = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 csr_req_i,
  input  logic                                 csr_we_i,
  input  logic [11:0]                          csr_addr_i,
  input  logic [31:0]                          csr_wdata_i,
  input  priv_lvl_t                            priv_lvl_i,
  output logic                                 csr_rvalid_o,
  output logic [31:0]                          csr_rdata_o,
  output logic                                 csr_err_o,
  output logic [NR_ENTRIES-1:0][PMP_LEN-1:0]   conf_addr_o,
  output pmpcfg_t [NR_ENTRIES-1:0]             conf_o,
  output logic                                 flush_o
);

  logic        is_cfg, is_addr, legal, wr;
  logic [1:0]  cfg_idx;
  logic [3:0]  addr_idx;
  logic [31:0] rd;
  logic [NR_ENTRIES-1:0] changed;

  logic        rvalid_d, rvalid_q;
  logic        err_d, err_q;
  logic        flush_d, flush_q;
  logic [31:0] rdata_d, rdata_q;

  assign is_cfg   = csr_addr_i[11:2] == CSR_PMPCFG0[11:2];
  assign is_addr  = csr_addr_i[11:4] == CSR_PMPADDR0[11:4];
  assign legal    = csr_req_i && (priv_lvl_i == PRIV_LVL_M) && (is_cfg || is_addr);
  assign wr       = legal && csr_we_i;
  assign cfg_idx  = csr_addr_i[1:0];
  assign addr_idx = csr_addr_i[3:0];

  for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_entry
    logic next_locked_tor;
    if (i + 1 < NR_ENTRIES) begin : g_next
      assign next_locked_tor = conf_o[i+1].locked && (conf_o[i+1].addr_mode == TOR);
    end else begin : g_last
      assign next_locked_tor = 1'b0;
    end

    pmp_entry_reg #(.PMP_LEN(PMP_LEN)) u_entry (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .cfg_we_i          (wr && is_cfg && (cfg_idx == 2'(i / 4))),
      .cfg_wdata_i       (pmpcfg_t'(csr_wdata_i[8*(i%4) +: 8])),
      .addr_we_i         (wr && is_addr && (addr_idx == 4'(i))),
      .addr_wdata_i      (csr_wdata_i[PMP_LEN-1:0]),
      .next_locked_tor_i (next_locked_tor),
      .conf_o            (conf_o[i]),
      .conf_addr_o       (conf_addr_o[i]),
      .changed_o         (changed[i])
    );
  end

  // Unimplemented entries simply never match, so they read as zero
  always_comb begin
    rd = '0;
    for (int e = 0; e < NR_ENTRIES; e++) begin
      if (is_cfg && (cfg_idx == 2'(e / 4))) begin
        rd[8*(e%4) +: 8] = conf_o[e];
      end
      if (is_addr && (addr_idx == 4'(e))) begin
        rd = 32'(conf_addr_o[e]);
      end
    end
  end

  always_comb begin
    rvalid_d = csr_req_i;
    err_d    = csr_req_i && !legal;
    rdata_d  = (legal && !csr_we_i) ? rd : 32'h0;
    flush_d  = |changed;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      flush_q  <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      flush_q  <= flush_d;
    end
  end

  assign csr_rvalid_o = rvalid_q;
  assign csr_err_o    = err_q;
  assign csr_rdata_o  = rdata_q;
  assign flush_o      = flush_q;

endmodule
